// File: rtl/irq_pkg.sv
// Shared types and helpers for the interrupt request latch that fronts the
// 8:3 priority encoder.
package irq_pkg;

  localparam int NUM_SOURCES = 8;
  localparam int ID_W        = 3;

  typedef logic [NUM_SOURCES-1:0] src_vec_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] index;
  } highest_t;

  // Ascending scan so the last hit seen is the highest-priority set bit.
  function automatic highest_t highest_set(input src_vec_t vec);
    highest_t result;
    result = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (vec[i]) begin
        result.valid = 1'b1;
        result.index = ID_W'(i);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/request_synchronizer.sv
// Plain multi-flop synchroniser chain for a bus of independent async lines.
module request_synchronizer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] synced
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= raw;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign synced = stages[DEPTH-1];

endmodule

// File: rtl/interrupt_request_latch_8.sv
// Request latch, mask and in-service threshold feeding the 8:3 priority
// encoder; the encoder's result comes back as the acknowledge ID.
module interrupt_request_latch_8
  import irq_pkg::*;
#(
  parameter int              SYNC_STAGES = 2,
  parameter logic [7:0]      EDGE_MODE   = 8'hFF,
  parameter logic [7:0]      MASK_RESET  = 8'hFF
) (
  input  logic            Clock_In,
  input  logic            Reset_N_In,
  input  logic [7:0]      Request_In,
  input  logic            Mask_Write_In,
  input  logic [7:0]      Mask_Data_In,
  input  logic            Ack_In,
  input  logic [ID_W-1:0] Ack_Id_In,
  input  logic            Eoi_In,
  input  logic [ID_W-1:0] Eoi_Id_In,
  output logic [7:0]      Request_Vector_Out,
  output logic            Interrupt_Out,
  output logic [7:0]      Mask_Out,
  output logic [7:0]      In_Service_Out
);

  src_vec_t sync_req, prev_req, pending, in_service, mask;
  src_vec_t set_vec, ack_clr, eoi_clr, above_thresh;
  logic     ack_hit;
  highest_t top_isr;

  request_synchronizer #(.WIDTH(NUM_SOURCES), .DEPTH(SYNC_STAGES)) sync_chain (
    .clk    (Clock_In),
    .rst_n  (Reset_N_In),
    .raw    (Request_In),
    .synced (sync_req)
  );

  // Level sources stop re-requesting while their handler is in service.
  always_comb begin
    set_vec = (EDGE_MODE & sync_req & ~prev_req) | (~EDGE_MODE & sync_req & ~in_service);
    ack_hit = Ack_In & pending[Ack_Id_In] & ~mask[Ack_Id_In];
    ack_clr = '0;
    if (ack_hit) ack_clr[Ack_Id_In] = 1'b1;
    eoi_clr = '0;
    if (Eoi_In) eoi_clr[Eoi_Id_In] = 1'b1;
  end

  always_ff @(posedge Clock_In or negedge Reset_N_In) begin
    if (!Reset_N_In) begin
      prev_req   <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= MASK_RESET;
    end else begin
      prev_req   <= sync_req;
      pending    <= (pending & ~ack_clr) | set_vec;
      in_service <= (in_service & ~eoi_clr) | ack_clr;
      if (Mask_Write_In) mask <= Mask_Data_In;
    end
  end

  // Only sources strictly above the highest in-service level may interrupt.
  always_comb begin
    top_isr = highest_set(in_service);
    above_thresh = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      above_thresh[i] = ~top_isr.valid | (i > int'(top_isr.index));
    end
  end

  assign Request_Vector_Out = pending & ~mask & above_thresh;
  assign Interrupt_Out      = |Request_Vector_Out;
  assign Mask_Out           = mask;
  assign In_Service_Out     = in_service;

endmodule

// File: tb/tb_interrupt_request_latch_8.sv
// Scoreboard bench: the driver predicts each edge with a behavioural model,
// the monitor compares the DUT after every rising edge.
module tb_interrupt_request_latch_8;

  localparam int         SYNC       = 2;
  localparam logic [7:0] EDGE       = 8'hEF;
  localparam logic [7:0] MASK_RESET = 8'hFF;

  typedef struct packed {
    logic [7:0] rv;
    logic       irq;
    logic [7:0] mask;
    logic [7:0] isr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = '0;
  logic       mask_wr = 1'b0;
  logic [7:0] mask_data = '0;
  logic       ack = 1'b0;
  logic [2:0] ack_id = '0;
  logic       eoi = 1'b0;
  logic [2:0] eoi_id = '0;
  logic [7:0] rv_out, mask_out, isr_out;
  logic       irq_out;

  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;
  exp_t exp_q[$];

  // Behavioural model state
  logic [7:0] m_pend, m_isr, m_mask, m_prev;
  logic [7:0] m_pipe[$];

  interrupt_request_latch_8 #(.SYNC_STAGES(SYNC), .EDGE_MODE(EDGE), .MASK_RESET(MASK_RESET)) dut (
    .Clock_In           (clk),
    .Reset_N_In         (rst_n),
    .Request_In         (req),
    .Mask_Write_In      (mask_wr),
    .Mask_Data_In       (mask_data),
    .Ack_In             (ack),
    .Ack_Id_In          (ack_id),
    .Eoi_In             (eoi),
    .Eoi_Id_In          (eoi_id),
    .Request_Vector_Out (rv_out),
    .Interrupt_Out      (irq_out),
    .Mask_Out           (mask_out),
    .In_Service_Out     (isr_out)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    m_pend = '0; m_isr = '0; m_prev = '0; m_mask = MASK_RESET;
    m_pipe = {};
    for (int i = 0; i < SYNC; i++) m_pipe.push_back(8'h00);
  endtask

  function automatic exp_t predict();
    exp_t e;
    int   h = -1;
    for (int i = 0; i < 8; i++) if (m_isr[i]) h = i;
    e.rv = '0;
    for (int i = 0; i < 8; i++) e.rv[i] = m_pend[i] && !m_mask[i] && (i > h);
    e.irq  = (e.rv != 0);
    e.mask = m_mask;
    e.isr  = m_isr;
    return e;
  endfunction

  function automatic logic [2:0] encoderResult(input logic [7:0] v);
    logic [2:0] r = '0;
    for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
    return r;
  endfunction

  // Advances the model by one rising edge using the inputs now driven.
  task automatic modelEdge();
    logic [7:0] s, set_bits, new_pend, new_isr;
    bit         hit;
    if (!rst_n) begin
      modelReset();
      return;
    end
    s = m_pipe[SYNC-1];
    for (int i = 0; i < 8; i++)
      set_bits[i] = EDGE[i] ? (s[i] && !m_prev[i]) : (s[i] && !m_isr[i]);
    hit = ack && m_pend[ack_id] && !m_mask[ack_id];
    new_pend = m_pend;
    new_isr  = m_isr;
    if (hit) new_pend[ack_id] = 1'b0;
    new_pend = new_pend | set_bits;
    if (eoi) new_isr[eoi_id] = 1'b0;
    if (hit) new_isr[ack_id] = 1'b1;
    if (mask_wr) m_mask = mask_data;
    m_pend = new_pend;
    m_isr  = new_isr;
    m_prev = s;
    m_pipe.push_front(req);
    void'(m_pipe.pop_back());
  endtask

  task automatic applyStimulus(input bit rst_level, input logic [7:0] r,
                               input bit mw, input logic [7:0] md,
                               input bit a, input logic [2:0] aid,
                               input bit e, input logic [2:0] eid);
    @(negedge clk);
    rst_n = rst_level; req = r; mask_wr = mw; mask_data = md;
    ack = a; ack_id = aid; eoi = e; eoi_id = eid;
    modelEdge();
    exp_q.push_back(predict());
  endtask

  task automatic idle(input int n, input logic [7:0] r);
    for (int k = 0; k < n; k++) applyStimulus(1, r, 0, '0, 0, '0, 0, '0);
  endtask

  task automatic doAck(input logic [2:0] id, input logic [7:0] r);
    applyStimulus(1, r, 0, '0, 1, id, 0, '0);
  endtask

  task automatic doEoi(input logic [2:0] id, input logic [7:0] r);
    applyStimulus(1, r, 0, '0, 0, '0, 1, id);
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checks += 4;
    if (rv_out !== e.rv) begin
      failures++;
      $display("[TB] FAIL %s request_vector got=%h exp=%h t=%0t", tag, rv_out, e.rv, $time);
    end
    if (irq_out !== e.irq) begin
      failures++;
      $display("[TB] FAIL %s interrupt got=%b exp=%b t=%0t", tag, irq_out, e.irq, $time);
    end
    if (mask_out !== e.mask) begin
      failures++;
      $display("[TB] FAIL %s mask got=%h exp=%h t=%0t", tag, mask_out, e.mask, $time);
    end
    if (isr_out !== e.isr) begin
      failures++;
      $display("[TB] FAIL %s in_service got=%h exp=%h t=%0t", tag, isr_out, e.isr, $time);
    end
  endtask

  // Asserts reset away from any edge and checks the outputs clear at once.
  task automatic pulseReset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_reset", predict());
    applyStimulus(0, req, 0, '0, 0, '0, 0, '0);
    applyStimulus(1, req, 0, '0, 0, '0, 0, '0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("edge", e);
      end
    end
  end

  initial begin : driver
    logic [7:0] r;
    modelReset();
    #1 rst_n = 1'b0;
    #1 checkOutput("power_on_reset", predict());
    applyStimulus(0, '0, 0, '0, 0, '0, 0, '0);
    applyStimulus(1, '0, 1, 8'h00, 0, '0, 0, '0);
    idle(2, '0);

    // Edge on bit 3 held four clocks, then dropped; pending must persist.
    idle(4, 8'h08);
    idle(4, 8'h00);
    doAck(3, '0); doEoi(3, '0); idle(1, '0);

    // Bits 2 and 6 pending, ack 6 hides bit 2 until EOI 6.
    idle(2, 8'h44); idle(3, '0);
    doAck(6, '0); idle(2, '0);
    doEoi(6, '0); idle(2, '0);
    doAck(2, '0); doEoi(2, '0);

    // Nesting: bit 1 in service, bit 5 interrupts.
    idle(2, 8'h02); idle(3, '0);
    doAck(1, '0);
    idle(2, 8'h20); idle(3, '0);
    doAck(5, '0); idle(1, '0);
    doEoi(5, '0); doEoi(1, '0); idle(1, '0);

    // Level source 4 held high through ack and EOI.
    idle(4, 8'h10);
    doAck(4, 8'h10); idle(3, 8'h10);
    doEoi(4, 8'h10); idle(3, 8'h10);
    idle(1, '0);
    doAck(4, '0); doEoi(4, '0); idle(2, '0);

    // Pending bit 0, then a fresh edge on 0 lands with its ack.
    idle(2, 8'h01); idle(3, '0);
    applyStimulus(1, 8'h01, 0, '0, 0, '0, 0, '0);
    applyStimulus(1, 8'h01, 0, '0, 0, '0, 0, '0);
    doAck(0, 8'h01);
    idle(2, '0);
    doEoi(0, '0); idle(1, '0);

    // Masked edge on 7, unmask, acknowledge, then reset mid-service.
    applyStimulus(1, '0, 1, 8'hFF, 0, '0, 0, '0);
    idle(2, 8'h80); idle(3, '0);
    applyStimulus(1, '0, 1, 8'h7F, 0, '0, 0, '0);
    idle(1, '0);
    doAck(7, '0); idle(1, '0);
    pulseReset();
    idle(2, '0);

    // Randomised traffic with the encoder's answer fed back as ack ID.
    r = '0;
    for (int n = 0; n < 500; n++) begin
      exp_t cur;
      bit   mw, a, e, rl;
      cur = predict();
      if ($urandom_range(0, 2) == 0) r = 8'($urandom);
      mw = ($urandom_range(0, 15) == 0);
      a  = ($urandom_range(0, 3) == 0);
      e  = ($urandom_range(0, 4) == 0);
      rl = ($urandom_range(0, 199) != 0);
      applyStimulus(rl, r, mw, 8'($urandom) & 8'($urandom),
                    a, ($urandom_range(0, 4) == 0) ? 3'($urandom) : encoderResult(cur.rv),
                    e, 3'($urandom));
    end
    if ($urandom_range(0, 1) == 0) pulseReset();

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interrupt_request_latch_8.md
Name: interrupt_request_latch_8

Overview:
- Upstream front end for the 8:3 high-priority encoder.
- Synchronises eight raw request lines, detects edges or levels, and latches pending requests.
- Applies a mask and an in-service priority threshold, then presents the qualified request vector and an enable to the encoder's Data_0..7 / Enable_In inputs.
- The encoder's 3-bit result returns as the acknowledge ID, which closes the loop; together the two blocks form an 8259-style interrupt controller.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per request line; legal range 2..3.
- EDGE_MODE, 8'hFF: per-source trigger type; bit i = 1 means rising-edge triggered, 0 means level triggered.
- MASK_RESET, 8'hFF: mask value loaded at reset; 1 = masked.

Ports:
- Clock_In  in  1  single clock; all state changes on its rising edge.
- Reset_N_In  in  1  asynchronous, active-low reset.
- Request_In  in  8  raw interrupt requests, asynchronous to Clock_In; bit 7 has the highest priority.
- Mask_Write_In  in  1  load Mask_Data_In into the mask register.
- Mask_Data_In  in  8  new mask value; 1 = masked.
- Ack_In  in  1  one-cycle acknowledge of source Ack_Id_In.
- Ack_Id_In  in  3  acknowledged source index; driven from the encoder output.
- Eoi_In  in  1  one-cycle end-of-interrupt for source Eoi_Id_In.
- Eoi_Id_In  in  3  index of the source whose in-service bit is cleared.
- Request_Vector_Out  out  8  qualified requests; drives encoder Data_0_In..Data_7_In.
- Interrupt_Out  out  1  OR of Request_Vector_Out; drives encoder Enable_In and the CPU IRQ.
- Mask_Out  out  8  current mask register.
- In_Service_Out  out  8  current in-service register.

Behaviour:
- Reset (asynchronous, Reset_N_In = 0):
  - Synchroniser, previous-sample, Pending and In_Service registers clear to 0.
  - Mask loads MASK_RESET.
  - Request_Vector_Out = 0, Interrupt_Out = 0, Mask_Out = MASK_RESET, In_Service_Out = 0.
  - Reset asserted mid-operation discards all pending and in-service state immediately.
- Synchronisation: each Request_In bit passes through SYNC_STAGES flops to give S[i]. Register P[i] holds S[i] from the previous cycle.
- Set condition:
  - Edge source: set[i] = S[i] & ~P[i].
  - Level source: set[i] = S[i] & ~In_Service[i].
  - A line held high across reset release produces one edge (P resets to 0).
- Acknowledge:
  - ack_hit = Ack_In & Pending[Ack_Id_In] & ~Mask[Ack_Id_In].
  - On ack_hit: Pending[id] clears and In_Service[id] sets.
  - An ack without a hit is ignored; no state changes.
- End of interrupt: Eoi_In clears In_Service[Eoi_Id_In]. An EOI on a bit that is not in service is harmless.
- Pending update: Pending_next[i] = (Pending[i] & ~ack_clr[i]) | set[i]. Set wins over an ack clear in the same cycle.
- In-service update: EOI is applied first, then ack. If Ack and EOI target the same ID in the same cycle, the bit ends at 1.
- Mask: when Mask_Write_In = 1, Mask loads Mask_Data_In on the next edge. Masked sources still latch Pending; unmasking exposes them on the following cycle.
- Threshold:
  - H = index of the highest set In_Service bit, or -1 if none.
  - Request_Vector_Out[i] = Pending[i] & ~Mask[i] & (i > H).
  - This gives nesting: only strictly higher priority interrupts a serviced source.
- Outputs are combinational decodes of registers only, so they are glitch-free at clock granularity.
- Latency:
  - Request_In rising edge (meeting setup) to Request_Vector_Out high takes SYNC_STAGES+1 rising edges; 3 at default.
  - Ack / EOI / mask write affect the outputs after 1 edge.
- Request pulses shorter than one clock period may be missed; sources must hold each request for at least 2 clocks.

Decomposition:
- Package irq_pkg:
  - NUM_SOURCES = 8, ID_W = 3.
  - Typedef src_vec_t (8-bit).
  - Function highest_set(src_vec_t) returning {valid, index}.
- Sub-module request_synchronizer: parameterised width and depth flop chain with async active-low reset, instantiated once at width 8.

Test Plan:
- Release reset with Request_In = 0, then pulse Request_In[3] high for 4 clocks (mask = 8'h00) -> Request_Vector_Out = 8'h08 and Interrupt_Out = 1 exactly 3 edges later; Pending stays set after the request drops.
- Pending bits 2 and 6, Ack_In with Ack_Id_In = 6 -> In_Service_Out = 8'h40 and Request_Vector_Out = 8'h00 (bit 2 is below the threshold); after Eoi_In with Eoi_Id_In = 6 -> Request_Vector_Out = 8'h04.
- Bit 1 in service, new rising edge on bit 5 -> Request_Vector_Out = 8'h20 (nesting); ack 5 -> In_Service_Out = 8'h22.
- Level source 4 (EDGE_MODE = 8'hEF) held high: ack 4 -> Pending[4] = 0 while in service; Eoi 4 -> Pending[4] re-sets on the next edge and Request_Vector_Out = 8'h10.
- Edge on bit 0 coincident with Ack_In for ID 0 -> Pending[0] remains 1 (set wins) and In_Service[0] = 1.
- Mask = 8'hFF with an edge on bit 7 -> Interrupt_Out = 0; write mask 8'h7F -> Request_Vector_Out = 8'h80 on the next cycle. Assert Reset_N_In mid-service -> all outputs 0 and Mask_Out = 8'hFF asynchronously.
